// File: rtl/vsync_bus_writer.sv
// ---------------------------------------------------------------------------
// vsync_bus_writer
//
// Frame-synchronous bus master. Every DIVIDER-th rising edge of vsync it
// advances CHANNELS independent byte counters by STEP and then writes each
// counter, one per clock, to BASE_ADDR + ch*STRIDE on the chip bus. Typical
// targets are animated text cells, palette cycling and sprite coordinates.
//
// Optional feature macro: VSYNC_WRITER_DONE_EN
//   defined   -> done pulses high for the one cycle after the last write
//   undefined -> done is tied low and no extra register exists
//
// Ports
//   clk      in   1       system clock, posedge
//   reset    in   1       asynchronous, active-high reset
//   vsync    in   1       frame sync, already in the clk domain
//   enable   in   1       1 = updates allowed (sampled only while idle)
//   addr     out  ADDR_W  bus address, qualified by we
//   data     out  DATA_W  bus write data, qualified by we
//   we       out  1       write strobe, one write per high cycle
//   busy     out  1       high while the write burst is in progress
//   overrun  out  1       sticky: an update trigger arrived while busy
//   done     out  1       one-cycle end-of-burst pulse (macro dependent)
// ---------------------------------------------------------------------------
module vsync_bus_writer #(
    parameter int unsigned       ADDR_W    = 12,
    parameter int unsigned       DATA_W    = 8,
    parameter int unsigned       CHANNELS  = 4,
    parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(12'h400),
    parameter int unsigned       STRIDE    = 1,
    parameter int unsigned       STEP      = 1,
    parameter int unsigned       DIVIDER   = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              vsync,
    input  logic              enable,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data,
    output logic              we,
    output logic              busy,
    output logic              overrun,
    output logic              done
);

    localparam int unsigned       CH_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int unsigned       FR_W       = (DIVIDER > 1) ? $clog2(DIVIDER) : 1;
    localparam logic [CH_W-1:0]   LAST_CH    = CH_W'(CHANNELS - 1);
    localparam logic [FR_W-1:0]   LAST_FRAME = FR_W'(DIVIDER - 1);
    localparam logic [DATA_W-1:0] INC        = DATA_W'(STEP);
    localparam logic [ADDR_W-1:0] ADDR_INC   = ADDR_W'(STRIDE);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_WRITE = 1'b1
    } state_t;

    state_t            r_state;
    logic              r_vsync_d;
    logic [FR_W-1:0]   r_frame_cnt;
    logic [CH_W-1:0]   r_ch;
    logic [DATA_W-1:0] r_cnt [CHANNELS];
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_data;
    logic              r_we;
    logic              r_busy;
    logic              r_overrun;

    logic              w_rise;
    logic              w_trigger;
    logic [CH_W-1:0]   w_ch_next;

    assign w_rise    = vsync & ~r_vsync_d;
    // The divider keeps counting edges whatever the FSM or enable is doing,
    // so the update phase stays locked to the frame sequence.
    assign w_trigger = w_rise & (r_frame_cnt == LAST_FRAME);
    assign w_ch_next = r_ch + CH_W'(1);

    // NOTE: sequential state is assigned with <= only, so every register in
    // an always_ff samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_vsync_d   <= 1'b0;
            r_frame_cnt <= '0;
        end else begin
            r_vsync_d <= vsync;
            if (w_rise) begin
                r_frame_cnt <= (r_frame_cnt == LAST_FRAME) ? '0 : r_frame_cnt + FR_W'(1);
            end
        end
    end

`ifdef VSYNC_WRITER_DONE_EN
    logic r_done;
`endif

    // Outputs are registered: the cycle that leaves IDLE already presents
    // channel 0, so a rise sampled at edge n gives we=1 right after edge n.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_ch      <= '0;
            r_addr    <= BASE_ADDR;
            r_data    <= '0;
            r_we      <= 1'b0;
            r_busy    <= 1'b0;
            r_overrun <= 1'b0;
            // NOTE: the counters are a flop array with defined start values
            // (cnt[i]=i), not a RAM, so every entry is reset explicitly.
            for (int i = 0; i < int'(CHANNELS); i++) begin
                r_cnt[i] <= DATA_W'(i);
            end
`ifdef VSYNC_WRITER_DONE_EN
            r_done    <= 1'b0;
`endif
        end else begin
`ifdef VSYNC_WRITER_DONE_EN
            r_done <= 1'b0;
`endif
            // A trigger during a burst is dropped; only the flag records it.
            if (w_trigger && (r_state == S_WRITE)) begin
                r_overrun <= 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_trigger && enable) begin
                        for (int i = 0; i < int'(CHANNELS); i++) begin
                            r_cnt[i] <= r_cnt[i] + INC;
                        end
                        r_ch    <= '0;
                        r_addr  <= BASE_ADDR;
                        r_data  <= r_cnt[0] + INC;
                        r_we    <= 1'b1;
                        r_busy  <= 1'b1;
                        r_state <= S_WRITE;
                    end
                end

                S_WRITE: begin
                    // r_ch is the channel currently on the bus.
                    if (r_ch == LAST_CH) begin
                        r_we    <= 1'b0;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
`ifdef VSYNC_WRITER_DONE_EN
                        r_done  <= 1'b1;
`endif
                    end else begin
                        r_ch   <= w_ch_next;
                        // Stepping the address wraps naturally mod 2^ADDR_W.
                        r_addr <= r_addr + ADDR_INC;
                        r_data <= r_cnt[w_ch_next];
                    end
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign addr    = r_addr;
    assign data    = r_data;
    assign we      = r_we;
    assign busy    = r_busy;
    assign overrun = r_overrun;

`ifdef VSYNC_WRITER_DONE_EN
    assign done = r_done;
`else
    assign done = 1'b0;
`endif

endmodule

// File: tb/tb_vsync_bus_writer.sv
// ---------------------------------------------------------------------------
// tb_vsync_bus_writer
//
// Directed bench for vsync_bus_writer. Five instances with different
// parameter sets share clk/reset/vsync/enable; each scenario resets all of
// them and observes the one instance it targets. Outputs are sampled 1 time
// unit after the rising clock edge.
//   0 defaults                      1 DIVIDER=3
//   2 STEP=8'h40, CHANNELS=1        3 CHANNELS=8
//   4 STRIDE=2, BASE_ADDR=12'hFFE
// ---------------------------------------------------------------------------
module tb_vsync_bus_writer;

    localparam int N = 5;

`ifdef VSYNC_WRITER_DONE_EN
    localparam int DONE_EXP = 1;
`else
    localparam int DONE_EXP = 0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset;
    logic         vsync;
    logic         enable;
    logic [11:0]  addr_v [N];
    logic [7:0]   data_v [N];
    logic [N-1:0] we_v;
    logic [N-1:0] busy_v;
    logic [N-1:0] ovr_v;
    logic [N-1:0] done_v;

    int n_cmp = 0;
    int n_err = 0;

    vsync_bus_writer u_def (
        .clk(clk), .reset(reset), .vsync(vsync), .enable(enable),
        .addr(addr_v[0]), .data(data_v[0]), .we(we_v[0]), .busy(busy_v[0]),
        .overrun(ovr_v[0]), .done(done_v[0])
    );

    vsync_bus_writer #(.DIVIDER(3)) u_div (
        .clk(clk), .reset(reset), .vsync(vsync), .enable(enable),
        .addr(addr_v[1]), .data(data_v[1]), .we(we_v[1]), .busy(busy_v[1]),
        .overrun(ovr_v[1]), .done(done_v[1])
    );

    vsync_bus_writer #(.STEP(8'h40), .CHANNELS(1)) u_step (
        .clk(clk), .reset(reset), .vsync(vsync), .enable(enable),
        .addr(addr_v[2]), .data(data_v[2]), .we(we_v[2]), .busy(busy_v[2]),
        .overrun(ovr_v[2]), .done(done_v[2])
    );

    vsync_bus_writer #(.CHANNELS(8)) u_ch8 (
        .clk(clk), .reset(reset), .vsync(vsync), .enable(enable),
        .addr(addr_v[3]), .data(data_v[3]), .we(we_v[3]), .busy(busy_v[3]),
        .overrun(ovr_v[3]), .done(done_v[3])
    );

    vsync_bus_writer #(.STRIDE(2), .BASE_ADDR(12'hFFE)) u_wrap (
        .clk(clk), .reset(reset), .vsync(vsync), .enable(enable),
        .addr(addr_v[4]), .data(data_v[4]), .we(we_v[4]), .busy(busy_v[4]),
        .overrun(ovr_v[4]), .done(done_v[4])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // One-cycle vsync pulse; returns at the cycle showing the first write.
    task automatic pulse();
        vsync = 1'b1;
        tick();
        vsync = 1'b0;
    endtask

    task automatic do_reset(input int k, input logic [11:0] base);
        reset  = 1'b1;
        vsync  = 1'b0;
        enable = 1'b1;
        tick();
        check("rst_we",   32'(we_v[k]),   0);
        check("rst_busy", 32'(busy_v[k]), 0);
        check("rst_ovr",  32'(ovr_v[k]),  0);
        check("rst_done", 32'(done_v[k]), 0);
        check("rst_addr", 32'(addr_v[k]), 32'(base));
        check("rst_data", 32'(data_v[k]), 0);
        reset = 1'b0;
        idle(2);
    endtask

    // Checks n consecutive write cycles starting at the current cycle, then
    // the idle cycle that must follow.
    task automatic expect_burst(input int k, input logic [11:0] a0, input int stride,
                                input int n, input logic [7:0] d0, input logic [7:0] dstep);
        for (int i = 0; i < n; i++) begin
            logic [11:0] ea;
            logic [7:0]  ed;
            ea = a0 + 12'(i * stride);
            ed = d0 + 8'(i * int'(dstep));
            check("burst_we",   32'(we_v[k]),   1);
            check("burst_busy", 32'(busy_v[k]), 1);
            check("burst_addr", 32'(addr_v[k]), 32'(ea));
            check("burst_data", 32'(data_v[k]), 32'(ed));
            check("burst_done", 32'(done_v[k]), 0);
            tick();
        end
        check("post_we",   32'(we_v[k]),   0);
        check("post_busy", 32'(busy_v[k]), 0);
    endtask

    initial begin
        int          wcount;
        int          last;
        logic [7:0]  exp3 [5];

        reset  = 1'b1;
        vsync  = 1'b0;
        enable = 1'b1;
        idle(2);

        // 1: defaults, single update
        do_reset(0, 12'h400);
        idle(5);
        pulse();
        expect_burst(0, 12'h400, 1, 4, 8'h01, 8'h01);
        check("t1_done", 32'(done_v[0]), DONE_EXP);
        tick();
        check("t1_done_end", 32'(done_v[0]), 0);
        check("t1_addr_hold", 32'(addr_v[0]), 32'h403);
        check("t1_data_hold", 32'(data_v[0]), 32'h04);

        // 2: DIVIDER=3, six rises -> bursts on the 3rd and 6th
        do_reset(1, 12'h400);
        wcount = 0;
        for (int r = 1; r <= 6; r++) begin
            pulse();
            check("t2_we", 32'(we_v[1]), (r % 3 == 0) ? 1 : 0);
            if (r == 3) check("t2_data3", 32'(data_v[1]), 32'h01);
            if (r == 6) check("t2_data6", 32'(data_v[1]), 32'h02);
            if (we_v[1]) wcount++;
            for (int j = 0; j < 6; j++) begin
                tick();
                if (we_v[1]) wcount++;
            end
        end
        check("t2_writes", 32'(wcount), 8);

        // 3: STEP=0x40, one channel, counter wraps
        exp3 = '{8'h40, 8'h80, 8'hC0, 8'h00, 8'h40};
        do_reset(2, 12'h400);
        for (int r = 0; r < 5; r++) begin
            pulse();
            check("t3_we",   32'(we_v[2]),   1);
            check("t3_addr", 32'(addr_v[2]), 32'h400);
            check("t3_data", 32'(data_v[2]), 32'(exp3[r]));
            tick();
            check("t3_we_off", 32'(we_v[2]), 0);
            idle(2);
        end

        // 4: CHANNELS=8, trigger arrives mid-burst
        do_reset(3, 12'h400);
        pulse();
        wcount = we_v[3] ? 1 : 0;
        last   = 0;
        for (int i = 1; i < 30; i++) begin
            vsync = (i == 3);
            tick();
            if (i == 2) check("t4_ovr_pre", 32'(ovr_v[3]), 0);
            if (i == 7) check("t4_data7", 32'(data_v[3]), 32'h08);
            if (we_v[3]) begin
                wcount++;
                last = i;
            end
        end
        vsync = 1'b0;
        check("t4_writes", 32'(wcount), 8);
        check("t4_last",   32'(last),   7);
        check("t4_ovr",    32'(ovr_v[3]), 1);
        pulse();
        check("t4_next_we",   32'(we_v[3]),   1);
        check("t4_next_data", 32'(data_v[3]), 32'h02);
        idle(10);
        check("t4_ovr_sticky", 32'(ovr_v[3]), 1);
        reset = 1'b1;
        #1;
        check("t4_ovr_clr", 32'(ovr_v[3]), 0);
        tick();
        reset = 1'b0;

        // 5: enable gating, enable dropped mid-burst, address wrap
        do_reset(4, 12'hFFE);
        enable = 1'b0;
        pulse();
        check("t5_gate1", 32'(we_v[4]), 0);
        idle(3);
        pulse();
        check("t5_gate2", 32'(we_v[4]), 0);
        idle(3);
        enable = 1'b1;
        pulse();
        enable = 1'b0;
        expect_burst(4, 12'hFFE, 2, 4, 8'h01, 8'h01);
        enable = 1'b1;
        idle(2);

        // 6: reset mid-burst, then counters restart
        do_reset(0, 12'h400);
        pulse();
        tick();
        check("t6_we_mid", 32'(we_v[0]), 1);
        reset = 1'b1;
        #1;
        check("t6_we_async",   32'(we_v[0]),   0);
        check("t6_busy_async", 32'(busy_v[0]), 0);
        tick();
        reset = 1'b0;
        idle(2);
        pulse();
        expect_burst(0, 12'h400, 1, 4, 8'h01, 8'h01);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
